// File: rtl/neureka_tcdm_split_reorder_if.sv
// Bus bundle between the wide HCI-style initiator and the MP narrow TCDM ports.
// Handshakes: wide request fires on wide_req & wide_gnt, a port request on tcdm_req & tcdm_gnt,
// a wide read beat on wide_r_valid & wide_r_ready; tcdm_r_valid has no backpressure.
interface neureka_tcdm_split_reorder_if #(
  parameter int unsigned BW = 288,
  parameter int unsigned MP = BW / 32
);
  logic                 wide_req;
  logic                 wide_gnt;
  logic [31:0]          wide_add;
  logic                 wide_wen;
  logic [BW/8-1:0]      wide_be;
  logic [BW-1:0]        wide_data;
  logic [BW-1:0]        wide_r_data;
  logic                 wide_r_valid;
  logic                 wide_r_ready;
  logic [MP-1:0]        tcdm_req;
  logic [MP-1:0]        tcdm_gnt;
  logic [MP-1:0][31:0]  tcdm_add;
  logic [MP-1:0]        tcdm_wen;
  logic [MP-1:0][3:0]   tcdm_be;
  logic [MP-1:0][31:0]  tcdm_data;
  logic [MP-1:0][31:0]  tcdm_r_data;
  logic [MP-1:0]        tcdm_r_valid;

  modport slave (
    input  wide_req, wide_add, wide_wen, wide_be, wide_data, wide_r_ready,
    input  tcdm_gnt, tcdm_r_data, tcdm_r_valid,
    output wide_gnt, wide_r_data, wide_r_valid,
    output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );

  modport master (
    output wide_req, wide_add, wide_wen, wide_be, wide_data, wide_r_ready,
    output tcdm_gnt, tcdm_r_data, tcdm_r_valid,
    input  wide_gnt, wide_r_data, wide_r_valid,
    input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );
endinterface

// File: rtl/neureka_tcdm_split_reorder.sv
// Splits a wide initiator request into MP independently handshaking 32-bit TCDM ports
// and re-aligns per-port read responses in small FIFOs into one wide beat.
module neureka_tcdm_split_reorder #(
  parameter int unsigned BW         = 288,
  parameter int unsigned MP         = BW / 32,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  neureka_tcdm_split_reorder_if.slave   bus,
  output logic                          busy_o
);
  localparam int unsigned CW      = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW      = $clog2(RESP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RESP_DEPTH - 1);

  logic [MP-1:0]   r_done;
  logic [CW-1:0]   r_credit [MP];
  logic [CW-1:0]   r_count  [MP];
  logic [PW-1:0]   r_wptr   [MP];
  logic [PW-1:0]   r_rptr   [MP];
  logic [31:0]     r_mem    [MP][RESP_DEPTH];

  logic [MP-1:0]   w_req;
  logic [MP-1:0]   w_hs;
  logic [MP-1:0]   w_nonempty;
  logic [MP-1:0]   w_credit_nz;
  logic            w_gnt;
  logic            w_valid;
  logic            w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_C) ? '0 : ptr + PW'(1);
  endfunction

  always_comb begin
    bus.wide_r_data = '0;
    w_req           = '0;
    w_nonempty      = '0;
    w_credit_nz     = '0;
    for (int p = 0; p < MP; p++) begin
      bus.tcdm_add[p]  = bus.wide_add + 32'(4 * p);
      bus.tcdm_be[p]   = bus.wide_be[4*p +: 4];
      bus.tcdm_data[p] = bus.wide_data[32*p +: 32];
      bus.tcdm_wen[p]  = bus.wide_wen;
      // A read is only issued if its response is guaranteed a FIFO slot.
      w_req[p]         = bus.wide_req & ~r_done[p] & (~bus.wide_wen | (r_credit[p] < DEPTH_C));
      w_nonempty[p]    = (r_count[p] != '0);
      w_credit_nz[p]   = (r_credit[p] != '0);
      bus.wide_r_data[32*p +: 32] = r_mem[p][r_rptr[p]];
    end
    w_hs             = w_req & bus.tcdm_gnt;
    w_gnt            = bus.wide_req & (&(r_done | w_hs));
    w_valid          = &w_nonempty;
    w_pop            = w_valid & bus.wide_r_ready;
    bus.tcdm_req     = w_req;
    bus.wide_gnt     = w_gnt;
    bus.wide_r_valid = w_valid;
    busy_o           = (|r_done) | (|w_credit_nz) | (|w_nonempty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done <= '0;
      for (int p = 0; p < MP; p++) begin
        r_credit[p] <= '0;
        r_count[p]  <= '0;
        r_wptr[p]   <= '0;
        r_rptr[p]   <= '0;
      end
    end else if (clear_i) begin
      r_done <= '0;
      for (int p = 0; p < MP; p++) begin
        r_credit[p] <= '0;
        r_count[p]  <= '0;
        r_wptr[p]   <= '0;
        r_rptr[p]   <= '0;
      end
    end else begin
      if (w_gnt) r_done <= '0;
      else       r_done <= r_done | w_hs;
      for (int p = 0; p < MP; p++) begin
        // Credits track reads issued but not yet popped (in flight plus queued).
        if ((w_hs[p] & bus.wide_wen) & ~w_pop)
          r_credit[p] <= r_credit[p] + CW'(1);
        else if (~(w_hs[p] & bus.wide_wen) & w_pop)
          r_credit[p] <= r_credit[p] - CW'(1);
        if (bus.tcdm_r_valid[p]) r_wptr[p] <= next_ptr(r_wptr[p]);
        if (w_pop)               r_rptr[p] <= next_ptr(r_rptr[p]);
        if (bus.tcdm_r_valid[p] & ~w_pop)
          r_count[p] <= r_count[p] + CW'(1);
        else if (~bus.tcdm_r_valid[p] & w_pop)
          r_count[p] <= r_count[p] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      if (bus.tcdm_r_valid[p]) r_mem[p][r_wptr[p]] <= bus.tcdm_r_data[p];
    end
  end

endmodule
